// File: rtl/multi_edge_pulse_gen.sv
// ----------------------------------------------------------------------------
// multi_edge_pulse_gen
//
// Multi-channel edge-to-pulse converter. Every channel samples a level input,
// detects rising, falling or both edges (shared mode select) and emits a
// clk-synchronous pulse stretched to STRETCH cycles. An edge that lands on a
// pulse still in flight either reloads the stretch counter (i_retrig = 1) or
// is dropped (i_retrig = 0); in both cases the channel's sticky overrun flag
// is set.
//
// Optional build macro:
//   MULTI_EDGE_PULSE_SYNC_EN  - inserts a two-flop synchronizer per channel
//                               ahead of the sample register (asynchronous
//                               inputs). Adds 2 cycles of latency.
//                               Undefined: i_in must be synchronous to clk.
//
// Parameters:
//   CHANNELS  number of independent channels (>= 1)
//   CNT_W     width of the per-channel stretch counter
//   STRETCH   pulse width in cycles, 1 .. 2^CNT_W-1
//
// Ports:
//   clk          clock, all state updates on the rising edge
//   rst_n        asynchronous active-low reset
//   i_in         level inputs, one bit per channel
//   i_mode       edge select: 00 rising, 01 falling, 10 both, 11 disabled
//   i_retrig     1: edge during an active pulse reloads the counter
//   i_ovr_clr    synchronous clear of all overrun flags (a new set wins)
//   o_pulse      stretched pulses, registered
//   o_overrun    sticky per-channel overrun flags, registered
// ----------------------------------------------------------------------------
module multi_edge_pulse_gen #(
    parameter int unsigned CHANNELS = 4,
    parameter int unsigned CNT_W    = 8,
    parameter int unsigned STRETCH  = 1
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic [CHANNELS-1:0] i_in,
    input  logic [1:0]          i_mode,
    input  logic                i_retrig,
    input  logic                i_ovr_clr,
    output logic [CHANNELS-1:0] o_pulse,
    output logic [CHANNELS-1:0] o_overrun
);

    // ------------------------------------------------------------------------
    // Elaboration-time parameter checks
    // ------------------------------------------------------------------------
    if (CHANNELS < 1) begin : g_bad_channels
        $error("multi_edge_pulse_gen: CHANNELS must be at least 1");
    end

    if (CNT_W < 1 || CNT_W > 62) begin : g_bad_cnt_w
        $error("multi_edge_pulse_gen: CNT_W must be in 1..62");
    end

    if (STRETCH < 1 || longint'(STRETCH) > ((longint'(1) << CNT_W) - 1)) begin : g_bad_stretch
        $error("multi_edge_pulse_gen: STRETCH must be in 1 .. 2^CNT_W-1");
    end

    // ------------------------------------------------------------------------
    // Local constants and types
    // ------------------------------------------------------------------------
`ifdef MULTI_EDGE_PULSE_SYNC_EN
    localparam int unsigned PRIME = 3;
`else
    localparam int unsigned PRIME = 1;
`endif

    // The prime counter saturates at PRIME + 1, so it needs room for that value.
    localparam int unsigned PW = $clog2(PRIME + 2);

    localparam logic [PW-1:0]    PRIME_DONE = PW'(PRIME + 1);
    localparam logic [CNT_W-1:0] STRETCH_V  = CNT_W'(STRETCH);
    localparam logic [CNT_W-1:0] CNT_ONE    = CNT_W'(1);

    typedef enum logic [1:0] {
        MODE_RISE = 2'b00,
        MODE_FALL = 2'b01,
        MODE_BOTH = 2'b10,
        MODE_OFF  = 2'b11
    } edge_mode_e;

    // ------------------------------------------------------------------------
    // Signals
    // ------------------------------------------------------------------------
    logic [CHANNELS-1:0] w_samp_src;      // what the sample register captures
    logic [CHANNELS-1:0] r_s;             // sample register
    logic [CHANNELS-1:0] r_h;             // history register (r_s delayed)
    logic [PW-1:0]       r_prime;         // clocks elapsed since reset, saturating
    logic                w_primed;        // sample and history both hold real data
    logic [CHANNELS-1:0] w_edge_raw;      // edge term for the selected mode
    logic [CHANNELS-1:0] w_edge;          // edge term after priming gate
    logic [CNT_W-1:0]    r_cnt   [CHANNELS];
    logic [CNT_W-1:0]    w_cnt_d [CHANNELS];
    logic [CHANNELS-1:0] w_ovr_set;
    logic [CHANNELS-1:0] w_pulse_d;
    logic [CHANNELS-1:0] r_pulse;
    logic [CHANNELS-1:0] r_overrun;
    edge_mode_e          w_mode;

    assign w_mode = edge_mode_e'(i_mode);

    // ------------------------------------------------------------------------
    // Optional input synchronizer
    // ------------------------------------------------------------------------
`ifdef MULTI_EDGE_PULSE_SYNC_EN
    logic [CHANNELS-1:0] r_sync1;
    logic [CHANNELS-1:0] r_sync2;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sync1 <= '0;
            r_sync2 <= '0;
        end else begin
            r_sync1 <= i_in;
            r_sync2 <= r_sync1;
        end
    end

    assign w_samp_src = r_sync2;
`else
    assign w_samp_src = i_in;
`endif

    // ------------------------------------------------------------------------
    // Priming
    // ------------------------------------------------------------------------
    // PRIME clocks fill the stages up to and including r_s with real input
    // data; one further clock is needed before r_h is real too. Until then
    // the s/h pair would compare live data against a reset zero and report a
    // phantom edge for any input that was already high at reset release.
    assign w_primed = (r_prime == PRIME_DONE);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_prime <= '0;
        end else if (!w_primed) begin
            r_prime <= r_prime + PW'(1);
        end
    end

    // ------------------------------------------------------------------------
    // Edge detection
    // ------------------------------------------------------------------------
    always_comb begin
        w_edge_raw = '0;
        case (w_mode)
            MODE_RISE: w_edge_raw = r_s & ~r_h;
            MODE_FALL: w_edge_raw = ~r_s & r_h;
            MODE_BOTH: w_edge_raw = r_s ^ r_h;
            MODE_OFF:  w_edge_raw = '0;
            default:   w_edge_raw = '0;
        endcase
    end

    assign w_edge = w_primed ? w_edge_raw : '0;

    // ------------------------------------------------------------------------
    // Stretch counters and overrun detection
    // ------------------------------------------------------------------------
    // An edge arriving in the cycle the counter is already 0 is a normal load,
    // so back-to-back pulses with no gap never flag an overrun.
    always_comb begin
        for (int i = 0; i < int'(CHANNELS); i++) begin
            w_cnt_d[i]   = r_cnt[i];
            w_ovr_set[i] = 1'b0;

            if (w_edge[i]) begin
                if (r_cnt[i] == '0) begin
                    w_cnt_d[i] = STRETCH_V;
                end else begin
                    w_ovr_set[i] = 1'b1;
                    w_cnt_d[i]   = i_retrig ? STRETCH_V : (r_cnt[i] - CNT_ONE);
                end
            end else if (r_cnt[i] != '0) begin
                w_cnt_d[i] = r_cnt[i] - CNT_ONE;
            end

            // Registered pulse mirrors the next counter value, so it is high
            // exactly while the counter is non-zero.
            w_pulse_d[i] = (w_cnt_d[i] != '0);
        end
    end

    // ------------------------------------------------------------------------
    // State registers
    // ------------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_s       <= '0;
            r_h       <= '0;
            r_pulse   <= '0;
            r_overrun <= '0;
            for (int i = 0; i < int'(CHANNELS); i++) begin
                r_cnt[i] <= '0;
            end
        end else begin
            r_s       <= w_samp_src;
            r_h       <= r_s;
            r_pulse   <= w_pulse_d;
            // A new overrun in the clear cycle survives the clear.
            r_overrun <= w_ovr_set | (r_overrun & ~{CHANNELS{i_ovr_clr}});
            for (int i = 0; i < int'(CHANNELS); i++) begin
                r_cnt[i] <= w_cnt_d[i];
            end
        end
    end

    // ------------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------------
    assign o_pulse   = r_pulse;
    assign o_overrun = r_overrun;

endmodule

// File: tb/tb_multi_edge_pulse_gen.sv
// ----------------------------------------------------------------------------
// tb_multi_edge_pulse_gen
//
// Three instances (STRETCH = 3, 1, 4) share one set of inputs. A behavioural
// model records every sampled input vector by clock number and derives the
// edges, counters and overrun flags from those samples. Each cycle the DUT
// outputs are compared against the model, and a few hand-computed literals
// pin the model's latency and widths.
// ----------------------------------------------------------------------------
module tb_multi_edge_pulse_gen;

    localparam int CH = 4;
    localparam int ND = 3;

`ifdef MULTI_EDGE_PULSE_SYNC_EN
    localparam int SD    = 2;   // extra synchronizer delay
    localparam int PRIME = 3;
`else
    localparam int SD    = 0;
    localparam int PRIME = 1;
`endif
    localparam int LAT = SD + 1;  // input-sample edge to pulse-rise edge

    logic          clk     = 1'b0;
    logic          rst_n   = 1'b0;
    logic [CH-1:0] in_v    = 4'b0001;
    logic [1:0]    mode    = 2'b00;
    logic          retrig  = 1'b0;
    logic          ovr_clr = 1'b0;

    logic [CH-1:0] dut_pulse [ND];
    logic [CH-1:0] dut_ovr   [ND];

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    multi_edge_pulse_gen #(.CHANNELS(CH), .CNT_W(8), .STRETCH(3)) u_dut0 (
        .clk       (clk),
        .rst_n     (rst_n),
        .i_in      (in_v),
        .i_mode    (mode),
        .i_retrig  (retrig),
        .i_ovr_clr (ovr_clr),
        .o_pulse   (dut_pulse[0]),
        .o_overrun (dut_ovr[0])
    );

    multi_edge_pulse_gen #(.CHANNELS(CH), .CNT_W(8), .STRETCH(1)) u_dut1 (
        .clk       (clk),
        .rst_n     (rst_n),
        .i_in      (in_v),
        .i_mode    (mode),
        .i_retrig  (retrig),
        .i_ovr_clr (ovr_clr),
        .o_pulse   (dut_pulse[1]),
        .o_overrun (dut_ovr[1])
    );

    multi_edge_pulse_gen #(.CHANNELS(CH), .CNT_W(8), .STRETCH(4)) u_dut2 (
        .clk       (clk),
        .rst_n     (rst_n),
        .i_in      (in_v),
        .i_mode    (mode),
        .i_retrig  (retrig),
        .i_ovr_clr (ovr_clr),
        .o_pulse   (dut_pulse[2]),
        .o_overrun (dut_ovr[2])
    );

    // ------------------------------------------------------------------------
    // Behavioural model
    // ------------------------------------------------------------------------
    int            st_of [ND] = '{3, 1, 4};
    int            clk_no = 0;           // clock edges since reset release
    logic [CH-1:0] samp [int];           // input vector seen at each clock
    int            mcnt [ND][CH];
    bit            movr [ND][CH];
    logic [CH-1:0] m_sv, m_hv, m_ev;
    bit            m_set;

    // Value held by the sample register after clock n.
    function automatic logic [CH-1:0] s_after(int n);
        if (n - SD >= 1 && samp.exists(n - SD)) return samp[n - SD];
        return '0;
    endfunction

    function automatic logic [CH-1:0] m_pulse(int d);
        logic [CH-1:0] r;
        for (int c = 0; c < CH; c++) r[c] = (mcnt[d][c] != 0);
        return r;
    endfunction

    function automatic logic [CH-1:0] m_ovr(int d);
        logic [CH-1:0] r;
        for (int c = 0; c < CH; c++) r[c] = movr[d][c];
        return r;
    endfunction

    initial begin
        forever begin
            @(posedge clk or negedge rst_n);
            if (!rst_n) begin
                clk_no = 0;
                samp.delete();
                for (int d = 0; d < ND; d++)
                    for (int c = 0; c < CH; c++) begin
                        mcnt[d][c] = 0;
                        movr[d][c] = 1'b0;
                    end
            end else begin
                clk_no++;
                samp[clk_no] = in_v;
                m_sv = s_after(clk_no - 1);
                m_hv = s_after(clk_no - 2);
                case (mode)
                    2'b00:   m_ev = m_sv & ~m_hv;
                    2'b01:   m_ev = ~m_sv & m_hv;
                    2'b10:   m_ev = m_sv ^ m_hv;
                    default: m_ev = '0;
                endcase
                // History is real only once clk_no - 2 >= PRIME.
                if (clk_no - 2 < PRIME) m_ev = '0;
                for (int d = 0; d < ND; d++)
                    for (int c = 0; c < CH; c++) begin
                        m_set = 1'b0;
                        if (m_ev[c]) begin
                            if (mcnt[d][c] == 0) mcnt[d][c] = st_of[d];
                            else begin
                                m_set = 1'b1;
                                mcnt[d][c] = retrig ? st_of[d] : mcnt[d][c] - 1;
                            end
                        end else if (mcnt[d][c] != 0) begin
                            mcnt[d][c] = mcnt[d][c] - 1;
                        end
                        movr[d][c] = m_set | (movr[d][c] & ~ovr_clr);
                    end
            end
        end
    end

    // ------------------------------------------------------------------------
    // Checking helpers
    // ------------------------------------------------------------------------
    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic compare_all();
        for (int d = 0; d < ND; d++) begin
            chk($sformatf("pulse_dut%0d", d), 32'(dut_pulse[d]), 32'(m_pulse(d)));
            chk($sformatf("overrun_dut%0d", d), 32'(dut_ovr[d]), 32'(m_ovr(d)));
        end
    endtask

    task automatic cyc(input int n);
        repeat (n) begin
            @(negedge clk);
            compare_all();
        end
    endtask

    // ------------------------------------------------------------------------
    // Directed stimulus
    // ------------------------------------------------------------------------
    int first_hi, last_hi, n_hi;

    initial begin
        // Reset state
        cyc(1);
        chk("reset_pulse", 32'(dut_pulse[0]), 32'h0);
        chk("reset_overrun", 32'(dut_ovr[2]), 32'h0);
        cyc(2);

        // Release reset with in[0] already high: no pulse
        rst_n = 1'b1;
        n_hi  = 0;
        for (int i = 0; i < 10; i++) begin
            cyc(1);
            if (dut_pulse[0][0]) n_hi++;
        end
        chk("rst_in_high_no_pulse", 32'(n_hi), 32'd0);

        // Stretch width on dut0 (STRETCH = 3)
        in_v[0] = 1'b0;
        cyc(6);
        in_v[0] = 1'b1;
        first_hi = 0;
        n_hi     = 0;
        for (int i = 1; i <= 12; i++) begin
            cyc(1);
            if (dut_pulse[0][0]) begin
                if (n_hi == 0) first_hi = i;
                n_hi++;
            end
        end
        chk("stretch_start", 32'(first_hi), 32'(LAT + 1));
        chk("stretch_width", 32'(n_hi), 32'd3);

        // Both edges on dut1 (STRETCH = 1): in[2] high 5 cycles
        mode    = 2'b10;
        in_v[2] = 1'b1;
        first_hi = 0;
        last_hi  = 0;
        n_hi     = 0;
        for (int i = 1; i <= 16; i++) begin
            cyc(1);
            if (dut_pulse[1][2]) begin
                if (n_hi == 0) first_hi = i;
                last_hi = i;
                n_hi++;
            end
            if (i == 5) in_v[2] = 1'b0;
        end
        chk("both_count", 32'(n_hi), 32'd2);
        chk("both_gap", 32'(last_hi - first_hi), 32'd5);
        chk("both_no_overrun", 32'(dut_ovr[1][2]), 32'd0);

        // Retrigger on dut2 (STRETCH = 4): rise, fall, rise 2 cycles later
        mode    = 2'b00;
        retrig  = 1'b1;
        cyc(4);
        in_v[1] = 1'b1;
        n_hi    = 0;
        for (int i = 1; i <= 16; i++) begin
            cyc(1);
            if (dut_pulse[2][1]) n_hi++;
            if (i == 1) in_v[1] = 1'b0;
            if (i == 2) in_v[1] = 1'b1;
        end
        chk("retrig_width", 32'(n_hi), 32'd6);
        chk("retrig_overrun", 32'(dut_ovr[2][1]), 32'd1);

        // No retrigger: same stimulus, ovr_clr coincides with the new overrun
        retrig  = 1'b0;
        in_v[1] = 1'b0;
        cyc(4);
        in_v[1] = 1'b1;
        n_hi    = 0;
        for (int i = 1; i <= 16; i++) begin
            cyc(1);
            if (dut_pulse[2][1]) n_hi++;
            if (i == 1) in_v[1] = 1'b0;
            if (i == 2) in_v[1] = 1'b1;
            if (i == 2 + LAT) ovr_clr = 1'b1;
            if (i == 3 + LAT) ovr_clr = 1'b0;
        end
        chk("noretrig_width", 32'(n_hi), 32'd4);
        chk("set_beats_clear", 32'(dut_ovr[2][1]), 32'd1);

        ovr_clr = 1'b1;
        cyc(1);
        ovr_clr = 1'b0;
        cyc(1);
        chk("clear_alone_dut2", 32'(dut_ovr[2]), 32'h0);
        chk("clear_alone_dut0", 32'(dut_ovr[0]), 32'h0);

        // Disable mid-pulse on dut2 ch3: pulse completes, new edges ignored
        in_v[1] = 1'b0;
        cyc(4);
        in_v[3] = 1'b1;
        n_hi    = 0;
        for (int i = 1; i <= 18; i++) begin
            cyc(1);
            if (dut_pulse[2][3]) n_hi++;
            if (i == LAT + 2) mode = 2'b11;
            if (i == LAT + 3) in_v[3] = 1'b0;
            if (i == LAT + 4) in_v[3] = 1'b1;
            if (i == LAT + 7) in_v[3] = 1'b0;
        end
        chk("disable_width", 32'(n_hi), 32'd4);

        // Reset mid-pulse: immediate drop, no replay after release
        mode = 2'b00;
        cyc(4);
        in_v[3] = 1'b1;
        cyc(LAT + 1);
        chk("pulse_before_reset", 32'(dut_pulse[2][3]), 32'd1);
        rst_n = 1'b0;
        #1;
        compare_all();
        chk("pulse_drops_async", 32'(dut_pulse[2]), 32'h0);
        cyc(2);
        rst_n = 1'b1;
        n_hi  = 0;
        for (int i = 0; i < 12; i++) begin
            cyc(1);
            if (dut_pulse[2][3]) n_hi++;
        end
        chk("no_replay_after_reset", 32'(n_hi), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/multi_edge_pulse_gen.md
# multi_edge_pulse_gen

Parametrised, multi-channel edge-to-pulse converter. Each channel samples an asynchronous or slow level input, detects rising, falling or both edges, and emits a clean `clk`-synchronous pulse stretched to a programmable number of cycles. It sits between raw level sources (buttons, sensor toggles, handshake wires) and the control logic that consumes single-cycle or fixed-width strobes. Each channel can optionally retrigger and keeps a sticky overrun flag.

## Interface
Parameters:
- `CHANNELS`, default 4: number of independent channels, at least 1.
- `CNT_W`, default 8: width of the per-channel stretch counter.
- `STRETCH`, default 1: pulse width in cycles.
  - Legal range 1 .. 2^CNT_W−1.
  - 0 or an out-of-range value is an elaboration error.

Ports:
- `clk` in 1: single clock. All state updates on its rising edge.
- `rst_n` in 1: asynchronous, active-low reset.
- `in` in CHANNELS: level inputs, one bit per channel.
- `mode` in 2: edge select, shared by all channels.
  - 00 rising, 01 falling, 10 both, 11 detection disabled.
- `retrig` in 1: 1 = an edge during an active pulse reloads the counter; 0 = that edge is ignored.
- `ovr_clr` in 1: synchronous clear of all overrun flags.
- `pulse` out CHANNELS: stretched output pulses. Registered.
- `overrun` out CHANNELS: sticky flag per channel. Registered.

## Operation
Per-channel datapath:
- Sample register `s`: the channel input, sampled each cycle.
- History register `h`: `s` delayed by one cycle.
- Edge term per mode:
  - Rising: s & ~h.
  - Falling: ~s & h.
  - Both: s ^ h.
  - Disabled: 0.
- Counter `cnt`, CNT_W bits. `pulse` is 1 exactly when `cnt` != 0.
- Counter update, in priority order:
  - Edge and `cnt` == 0: load STRETCH.
  - Edge, `cnt` != 0, `retrig` = 1: reload STRETCH and set `overrun`.
  - Edge, `cnt` != 0, `retrig` = 0: decrement and set `overrun`. The edge is lost.
  - No edge, `cnt` != 0: decrement.
  - Otherwise: hold.
- `overrun` is sticky.
  - Cleared only by `ovr_clr` or reset.
  - If set and `ovr_clr` occur in the same cycle, set wins.
- Priming after reset:
  - Edge detection is suppressed until the sample chain holds real data. PRIME = 1 cycle without the macro, 3 cycles with it.
  - An input that is already high at reset release produces no pulse.
- `mode` and `retrig` changes:
  - Take effect on the next detection cycle.
  - Never truncate or extend a pulse already in flight.
  - A switch to mode 11 lets in-flight pulses complete.
- Channels are fully independent. There is no shared arbitration.

## Timing
- Reset values: `pulse` = 0, `overrun` = 0, `cnt` = 0, `s` = 0, `h` = 0, sync stages = 0, prime counter = 0.
- Latency without the macro:
  - `in` changes before clock edge k; `s` updates at edge k.
  - `pulse` rises at edge k+1.
- Latency with the macro: `pulse` rises at edge k+3.
- Pulse width: exactly STRETCH cycles when there is no retrigger.
  - STRETCH = 1 gives a single-cycle strobe.
- Back-to-back pulses:
  - An edge detected in the same cycle `cnt` reaches 0 loads normally with no overrun, since `cnt` == 0 at detection.
  - Minimum gap between pulses is 0 cycles.
- Reset asserted mid-pulse: `pulse` drops immediately (asynchronous). The edge is not replayed after release.
- Input toggling faster than the sample rate: only sampled transitions are seen. Glitch filtering is out of scope.

## Configuration
- `MULTI_EDGE_PULSE_SYNC_EN`
  - Defined: each channel gets a two-flop synchronizer ahead of `s`, adding 2 cycles of latency. PRIME = 3. For asynchronous inputs.
  - Undefined: `in` feeds `s` directly. PRIME = 1. `in` must be synchronous to `clk`.

## Test plan
- **Reset with input high:** CHANNELS=4, STRETCH=3, mode=00. Release reset with `in`=4'b0001 → `pulse` stays 0.
- **Stretch width:** `in`[0] rises after priming → `pulse[0]` high for exactly 3 cycles, starting 1 edge after sampling (no macro) or 3 edges (macro).
- **Both edges:** mode=10, STRETCH=1. `in`[2] high for 5 cycles, then low → two 1-cycle pulses, 5 cycles apart, `overrun`=0.
- **Retrigger:** mode=00, STRETCH=4, `retrig`=1. Rise on `in`[1], then fall and rise again 2 cycles later → `pulse[1]` high 6 cycles, `overrun[1]`=1.
- **No retrigger:** same stimulus with `retrig`=0 → `pulse[1]` high 4 cycles, `overrun[1]`=1. Assert `ovr_clr` together with a new overrun → flag stays 1. `ovr_clr` alone → flag 0.
- **Disable and reset mid-pulse:** switch to mode=11 mid-pulse → pulse completes and new edges are ignored. Assert `rst_n`=0 mid-pulse → `pulse` is 0 immediately and no pulse follows release.
